reaction_timer_ctrl: RTL and testbench
======================================

// Module: reaction_timer_ctrl
// PURPOSE
//  Top-level sequencer for the reaction-time tester. Runs the start -> random delay ->
//  GO -> press sequence and generates enable/stop/tick for the cascaded BCD counter chain.
//  Detects false starts and timeouts. Sits between the debounced push-buttons and the
//  counter/7-segment datapath.
// PARAMETERS
//  CLK_PER_MS       50000    clk cycles per 1 ms tick (>=2)
//  DELAY_MIN_MS     1000     minimum random pre-GO delay, ms
//  DELAY_SPAN_BITS  11       random delay adder = lfsr[DELAY_SPAN_BITS-1:0] ms (0..2047)
//  MAX_MS           9999     elapsed-ms limit in RUN; reaching it forces timeout
//  LFSR_SEED        16'hACE1 LFSR reset value, must be non-zero
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  start_btn    in   1   start button, level, already debounced/synchronised
//  react_btn    in   1   reaction button, level, already debounced/synchronised
//  cnt_enable   out  1   counter-chain enable; 0 clears all digits
//  cnt_stop     out  1   counter-chain stop; 1 latches the count for display
//  cnt_tick     out  1   one-clk pulse per ms in RUN; drives counter-chain advance
//  led_go       out  1   GO lamp, high in RUN only
//  done         out  1   result valid, high in DONE
//  foul         out  1   false start, high in FOUL
//  timeout      out  1   high in DONE when the exit was by MAX_MS, else 0
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, lfsr=LFSR_SEED, prescaler=0, delay_ms=0,
//    elapsed_ms=0, edge-detect regs=0, all outputs 0.
//  - Edge detect: *_rise = btn & ~btn_q (btn_q registered). Only rising edges act.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, steps every clk in every state.
//  - Prescaler: counts 0..CLK_PER_MS-1 in DELAY and RUN; cleared on entry to either.
//    ms_tick=1 on the cycle it wraps. First tick comes CLK_PER_MS cycles after entry.
//  - States:
//   IDLE : outputs 0. start_rise -> DELAY; delay_ms <= DELAY_MIN_MS + lfsr[span].
//   DELAY: ms_tick -> delay_ms-1. react_rise -> FOUL. ms_tick with delay_ms==1 -> RUN.
//          react_rise wins over the final tick in the same cycle.
//   RUN  : led_go=1, cnt_enable=1, cnt_tick=ms_tick (registered, 1 clk).
//          ms_tick -> elapsed_ms+1. react_rise -> DONE, timeout=0.
//          ms_tick with elapsed_ms==MAX_MS-1 and no react_rise -> DONE, timeout=1.
//          react_rise wins over a coincident limit tick.
//   DONE : cnt_enable=1, cnt_stop=1, done=1, timeout held. start_rise -> CLEAR.
//   FOUL : foul=1, cnt_enable=0. start_rise -> CLEAR.
//   CLEAR: one cycle, all outputs 0 (counter chain clears) -> DELAY with new delay_ms,
//          elapsed_ms=0.
//  - start_rise in DELAY/RUN is ignored. react_rise in IDLE/DONE/FOUL/CLEAR is ignored.
//  - All outputs are registered and decoded from the next state. They take effect on
//    the clock edge that changes state: zero-cycle output latency relative to the state.
//  - Widths: delay_ms and elapsed_ms are 14 bits. DELAY_MIN_MS + 2^DELAY_SPAN_BITS-1
//    must be < 2^14. No wrap-around can occur, because the MAX_MS exit precedes it.
//  - rst_n low in any state returns to IDLE on that edge. No partial round survives.
// STRUCTURE
//  - Shared package reaction_pkg: state enum (IDLE, DELAY, RUN, DONE, FOUL, CLEAR),
//    LFSR tap constant, MS_W=14.
//  - Sub-module ms_prescaler (clk, rst_n, clr, run -> tick) holds the parameterised
//    divider. The FSM, LFSR, delay and elapsed counters stay in this module.
// TESTING  (CLK_PER_MS=4, DELAY_MIN_MS=2, DELAY_SPAN_BITS=2, MAX_MS=10, seed 16'hACE1)
//  1. Reset mid-RUN -> next edge: state IDLE, every output 0, lfsr=16'hACE1.
//  2. start pulse, react at 3 ms into RUN -> cnt_tick x3, then done=1, cnt_stop=1,
//     timeout=0, led_go=0.
//  3. start, react during DELAY -> foul=1, cnt_enable=0, led_go never 1.
//  4. start, no react -> exactly 10 cnt_tick pulses in RUN, then done=1, timeout=1.
//  5. react_rise on the same cycle as the 10th ms_tick -> DONE with timeout=0.
//  6. From DONE, start -> one CLEAR cycle (cnt_enable=0), then DELAY. Delay lies in
//     2..5 ms and matches the model LFSR value.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time tester.
//   state_e    : sequencer states
//   dbg_t      : debug snapshot of sequencer state, LFSR and ms counters
//   LFSR_TAPS  : Galois mask for x^16+x^14+x^13+x^11
//   MS_W       : width of the delay and elapsed millisecond counters
//   lfsr_step  : one right-shift Galois LFSR step
package reaction_pkg;

  localparam int          MS_W      = 14;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FOUL  = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

  typedef struct packed {
    state_e            state;
    logic [15:0]       lfsr;
    logic [MS_W-1:0]   delay_ms;
    logic [MS_W-1:0]   elapsed_ms;
  } dbg_t;

  // Bit 0 shifts out and, when set, folds the tap mask back into the register.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler for the reaction-time tester.
//   clk   in  system clock
//   rst_n in  synchronous reset, active low
//   clr   in  restart the divider from 0 (state entry)
//   run   in  count while high, hold while low
//   tick  out one-cycle strobe on the cycle the divider wraps
// The first tick after clr is seen CLK_PER_MS clock edges later.
module ms_prescaler #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_PER_MS);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] r_cnt;

  // Not gated by clr: the DELAY->RUN tick itself is what asserts clr.
  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Top-level sequencer for the reaction-time tester.
// Runs start -> random delay -> GO -> press, drives the BCD counter chain
// (enable/stop/tick) and flags false starts and timeouts.
//   clk        in  system clock
//   rst_n      in  synchronous reset, active low
//   start_btn  in  start button level (debounced, synchronised)
//   react_btn  in  reaction button level (debounced, synchronised)
//   cnt_enable out counter-chain enable, 0 clears the digits
//   cnt_stop   out counter-chain stop, 1 freezes the count for display
//   cnt_tick   out one-clk pulse per ms while running
//   led_go     out GO lamp
//   done       out result valid
//   foul       out false start
//   timeout    out result ended by the MAX_MS limit
//   dbg        out state / LFSR / counter snapshot
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int          CLK_PER_MS      = 50000,
  parameter int          DELAY_MIN_MS    = 1000,
  parameter int          DELAY_SPAN_BITS = 11,
  parameter int          MAX_MS          = 9999,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_btn,
  input  logic react_btn,
  output logic cnt_enable,
  output logic cnt_stop,
  output logic cnt_tick,
  output logic led_go,
  output logic done,
  output logic foul,
  output logic timeout,
  output dbg_t dbg
);

  localparam logic [MS_W-1:0] DELAY_MIN = MS_W'(DELAY_MIN_MS);
  localparam logic [MS_W-1:0] LIMIT_M1  = MS_W'(MAX_MS - 1);

  state_e          r_state;
  logic [15:0]     r_lfsr;
  logic [MS_W-1:0] r_delay_ms;
  logic [MS_W-1:0] r_elapsed_ms;
  logic            r_start_q;
  logic            r_react_q;
  logic            r_cnt_enable;
  logic            r_cnt_stop;
  logic            r_cnt_tick;
  logic            r_led_go;
  logic            r_done;
  logic            r_foul;
  logic            r_timeout;

  state_e          w_next;
  logic            w_limit_exit;
  logic            w_start_rise;
  logic            w_react_rise;
  logic            w_ms_tick;
  logic            w_clr;
  logic            w_run;
  logic            w_enter_delay;
  logic [MS_W-1:0] w_new_delay;

  assign w_start_rise  = start_btn & ~r_start_q;
  assign w_react_rise  = react_btn & ~r_react_q;
  assign w_enter_delay = (w_next == ST_DELAY) && (r_state != ST_DELAY);
  assign w_run         = (r_state == ST_DELAY) || (r_state == ST_RUN);
  assign w_clr         = w_enter_delay || ((w_next == ST_RUN) && (r_state != ST_RUN));
  assign w_new_delay   = DELAY_MIN +
                         {{(MS_W-DELAY_SPAN_BITS){1'b0}}, r_lfsr[DELAY_SPAN_BITS-1:0]};

  ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .run   (w_run),
    .tick  (w_ms_tick)
  );

  // Next state. The reaction press takes priority over a coincident tick in
  // both DELAY (foul beats GO) and RUN (press beats the limit).
  always_comb begin
    w_next       = r_state;
    w_limit_exit = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_rise) w_next = ST_DELAY;
      ST_DELAY: begin
        if (w_react_rise)                           w_next = ST_FOUL;
        else if (w_ms_tick && (r_delay_ms == 1))    w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_react_rise) begin
          w_next = ST_DONE;
        end else if (w_ms_tick && (r_elapsed_ms == LIMIT_M1)) begin
          w_next       = ST_DONE;
          w_limit_exit = 1'b1;
        end
      end
      ST_DONE:  if (w_start_rise) w_next = ST_CLEAR;
      ST_FOUL:  if (w_start_rise) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_DELAY;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_delay_ms   <= '0;
      r_elapsed_ms <= '0;
      r_start_q    <= 1'b0;
      r_react_q    <= 1'b0;
      r_cnt_enable <= 1'b0;
      r_cnt_stop   <= 1'b0;
      r_cnt_tick   <= 1'b0;
      r_led_go     <= 1'b0;
      r_done       <= 1'b0;
      r_foul       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_lfsr    <= lfsr_step(r_lfsr);
      r_start_q <= start_btn;
      r_react_q <= react_btn;

      // A fresh delay is drawn every time DELAY is entered (IDLE or CLEAR).
      if (w_enter_delay)
        r_delay_ms <= w_new_delay;
      else if ((r_state == ST_DELAY) && w_ms_tick)
        r_delay_ms <= r_delay_ms - 1'b1;

      if (w_enter_delay)
        r_elapsed_ms <= '0;
      else if ((r_state == ST_RUN) && w_ms_tick)
        r_elapsed_ms <= r_elapsed_ms + 1'b1;

      // Every ms counted in RUN is forwarded, including the one that ends it,
      // so the display agrees with elapsed_ms.
      r_cnt_tick   <= (r_state == ST_RUN) && w_ms_tick;
      r_led_go     <= (w_next == ST_RUN);
      r_cnt_enable <= (w_next == ST_RUN) || (w_next == ST_DONE);
      r_cnt_stop   <= (w_next == ST_DONE);
      r_done       <= (w_next == ST_DONE);
      r_foul       <= (w_next == ST_FOUL);
      // Captured on the RUN->DONE edge, held while DONE persists.
      if (w_next == ST_DONE)
        r_timeout <= (r_state == ST_DONE) ? r_timeout : w_limit_exit;
      else
        r_timeout <= 1'b0;
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_stop   = r_cnt_stop;
  assign cnt_tick   = r_cnt_tick;
  assign led_go     = r_led_go;
  assign done       = r_done;
  assign foul       = r_foul;
  assign timeout    = r_timeout;

  assign dbg.state      = r_state;
  assign dbg.lfsr       = r_lfsr;
  assign dbg.delay_ms   = r_delay_ms;
  assign dbg.elapsed_ms = r_elapsed_ms;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
module tb_reaction_timer_ctrl;
  import reaction_pkg::*;

  localparam int          CPM   = 4;
  localparam int          DMIN  = 2;
  localparam int          SPAN  = 2;
  localparam int          MAXMS = 10;
  localparam logic [15:0] SEED  = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic start_btn = 1'b0;
  logic react_btn = 1'b0;
  logic cnt_enable, cnt_stop, cnt_tick, led_go, done, foul, timeout;
  dbg_t dbg;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .CLK_PER_MS(CPM), .DELAY_MIN_MS(DMIN), .DELAY_SPAN_BITS(SPAN),
    .MAX_MS(MAXMS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .react_btn(react_btn),
    .cnt_enable(cnt_enable), .cnt_stop(cnt_stop), .cnt_tick(cnt_tick),
    .led_go(led_go), .done(done), .foul(foul), .timeout(timeout), .dbg(dbg)
  );

  // ---------------- reference LFSR ----------------
  // x^16+x^14+x^13+x^11, right-shifting Galois form.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) begin
      n[15] = ~n[15]; n[13] = ~n[13]; n[12] = ~n[12]; n[10] = ~n[10];
    end
    return n;
  endfunction
  always @(posedge clk) m_lfsr <= !rst_n ? SEED : model_step(m_lfsr);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];
  logic go_seen = 1'b0;

  always @(negedge clk) if (led_go) go_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [13:0] model_delay();
    logic [1:0] lo;
    lo = m_lfsr[1:0];
    return 14'(DMIN) + {12'd0, lo};
  endfunction

  // Rising start from IDLE; returns the delay (ms) the DUT should have drawn.
  task automatic start_from_idle(output logic [13:0] d);
    start_btn = 1'b1;
    exp_q.push_back(model_delay());
    @(negedge clk);
    start_btn = 1'b0;
    d = exp_q.pop_front();
    check("idle_to_delay", dbg.state, ST_DELAY);
    check("idle_delay_ms", dbg.delay_ms, d);
  endtask

  // Rising start from DONE/FOUL: one CLEAR cycle, then DELAY.
  task automatic start_from_held(output logic [13:0] d);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("clear_state", dbg.state, ST_CLEAR);
    check("clear_outs", {cnt_enable, cnt_stop, cnt_tick, led_go, done, foul, timeout}, 0);
    exp_q.push_back(model_delay());
    @(negedge clk);
    d = exp_q.pop_front();
    check("clear_to_delay", dbg.state, ST_DELAY);
    check("new_delay_ms", dbg.delay_ms, d);
    check("delay_in_range", (d >= 2 && d <= 5), 1);
    check("elapsed_cleared", dbg.elapsed_ms, 0);
  endtask

  task automatic wait_go(output int cyc);
    cyc = 0;
    while (!led_go && cyc < 200) begin @(negedge clk); cyc++; end
    check("go_reached", led_go, 1);
  endtask

  task automatic count_until_done(output int pulses);
    int n;
    n = 0; pulses = 0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
      if (cnt_tick) pulses++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic count_pulses(input int target, output int pulses);
    int n;
    n = 0; pulses = 0;
    while (pulses < target && n < 200) begin
      @(negedge clk); n++;
      if (cnt_tick) pulses++;
    end
    check("pulse_target", pulses, target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [13:0] d;
    int cyc, p;

    tick_n(3);
    check("rst_state", dbg.state, ST_IDLE);
    check("rst_outs", {cnt_enable, cnt_stop, cnt_tick, led_go, done, foul, timeout}, 0);
    check("rst_lfsr", dbg.lfsr, SEED);
    rst_n = 1'b1;
    tick_n(2);
    check("lfsr_track", dbg.lfsr, m_lfsr);

    // Round 1: react 3 ms into RUN.
    start_from_idle(d);
    wait_go(cyc);
    check("delay_cycles", cyc, 4 * d);
    check("run_enable", cnt_enable, 1);
    count_pulses(3, p);
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    check("r1_state", dbg.state, ST_DONE);
    check("r1_done", done, 1);
    check("r1_stop", cnt_stop, 1);
    check("r1_timeout", timeout, 0);
    check("r1_go_off", led_go, 0);
    check("r1_enable", cnt_enable, 1);
    check("r1_elapsed", dbg.elapsed_ms, 3);
    tick_n(3);
    check("r1_held", {done, cnt_stop, timeout}, 3'b110);

    // Round 2: from DONE, false start during DELAY.
    start_from_held(d);
    go_seen = 1'b0;
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    check("foul_state", dbg.state, ST_FOUL);
    check("foul_flag", foul, 1);
    check("foul_enable", cnt_enable, 0);
    tick_n(30);
    check("foul_held", foul, 1);
    check("foul_no_go", go_seen, 0);

    // Round 3: from FOUL, no press -> timeout after 10 ms.
    start_from_held(d);
    wait_go(cyc);
    check("r3_delay_cycles", cyc, 4 * d);
    count_until_done(p);
    check("r3_pulses", p, MAXMS);
    check("r3_timeout", timeout, 1);
    check("r3_elapsed", dbg.elapsed_ms, MAXMS);
    check("r3_go_off", led_go, 0);
    tick_n(2);
    check("r3_timeout_held", timeout, 1);

    // Round 4: press lands on the same edge as the 10th ms tick.
    start_from_held(d);
    wait_go(cyc);
    count_pulses(9, p);
    tick_n(3);
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    check("r4_state", dbg.state, ST_DONE);
    check("r4_timeout", timeout, 0);
    check("r4_tenth_pulse", cnt_tick, 1);
    check("r4_elapsed", dbg.elapsed_ms, MAXMS);

    // Round 5: reset in the middle of RUN.
    start_from_held(d);
    wait_go(cyc);
    tick_n(5);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_state", dbg.state, ST_IDLE);
    check("midrun_outs", {cnt_enable, cnt_stop, cnt_tick, led_go, done, foul, timeout}, 0);
    check("midrun_lfsr", dbg.lfsr, SEED);
    check("midrun_counts", {dbg.delay_ms, dbg.elapsed_ms}, 0);
    rst_n = 1'b1;
    tick_n(7);
    check("post_rst_lfsr", dbg.lfsr, m_lfsr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
